filter_sequencer: RTL
=====================

Name: filter_sequencer

Overview:
Run controller for the filter processor and its dual-port frame memory. Holds the CPU in reset while idle, writes the selected filter code into a config word on memory port A, then releases the CPU. Detects the program's completion write, hands the frame to the display path, and flags timeouts. It owns port A only outside the RUN state. Port B, the display read port, is not touched by this block.

Parameters:
ADDR_W, 18, width of the port A address bus
DATA_W, 8, width of a memory data word
CFG_ADDR, 18'h3FFF0, word address where the filter code is written
DONE_ADDR, 18'h3FFF1, word address the program writes non-zero to when finished
TIMEOUT_CYCLES, 10_000_000, maximum number of RUN cycles before fault
CNT_W, 32, width of the cycle counter

Ports:
clk  in  1  system clock; all logic is on the rising edge
rst  in  1  synchronous, active-high reset
start  in  1  single-cycle pulse that requests a run
abort  in  1  cancels a run in progress
filter_sel  in  2  filter code (0 copy, 1 blur, 2 sharpen, 3 edge); sampled on start
cpu_mem_we  in  1  CPU data-memory write enable, snooped
cpu_mem_addr  in  ADDR_W  CPU data address, snooped
cpu_mem_wdata  in  DATA_W  CPU write data, low byte, snooped
cpu_rst  out  1  reset to the CPU (controller and datapath); 1 = held in reset
mem_sel  out  1  port A mux select; 1 = sequencer drives port A, 0 = CPU drives port A
mem_we  out  1  sequencer write enable for port A
mem_addr  out  ADDR_W  sequencer address for port A
mem_wdata  out  DATA_W  sequencer write data for port A
busy  out  1  high in CONFIG, CLEAR and RUN
done  out  1  run completed
error  out  1  run timed out
display_en  out  1  frame valid for display
cycles  out  CNT_W  number of RUN cycles in the last or current run

Behaviour:
- All outputs are registered. State changes only on the rising clk edge.
- rst dominates everything and applies in any state, including mid-run. On reset:
  - state = IDLE
  - cpu_rst = 1, mem_sel = 1, mem_we = 0, mem_addr = 0, mem_wdata = 0
  - busy = done = error = display_en = 0, cycles = 0
- IDLE:
  - CPU held in reset; sequencer owns port A with mem_we = 0.
  - start → CONFIG; latch filter_sel; clear cycles.
- CONFIG (exactly 1 cycle):
  - mem_we = 1, mem_addr = CFG_ADDR, mem_wdata = zero-extended latched code.
  - Always → CLEAR.
- CLEAR (exactly 1 cycle):
  - mem_we = 1, mem_addr = DONE_ADDR, mem_wdata = 0, so a stale flag cannot end the next run.
  - Always → RUN.
- RUN:
  - cpu_rst = 0, mem_sel = 0, mem_we = 0.
  - cycles increments once per RUN cycle and saturates at all-ones.
  - Done event: cpu_mem_we & (cpu_mem_addr == DONE_ADDR) & (cpu_mem_wdata != 0) → DONE.
  - Timeout: cycles == TIMEOUT_CYCLES-1 with no done event → FAULT.
  - Done and timeout in the same cycle: DONE wins.
  - abort → IDLE; abort has priority over done and timeout.
  - cpu_rst returns to 1 in the cycle after leaving RUN.
- DONE:
  - done = 1, display_en = 1, cpu_rst = 1, mem_sel = 1, cycles frozen.
  - start → CONFIG; done and display_en drop with the transition.
  - abort is ignored.
- FAULT:
  - error = 1, cpu_rst = 1, mem_sel = 1, display_en = 0, cycles frozen.
  - start → CONFIG, which clears error.
- start is ignored in CONFIG, CLEAR and RUN. abort is ignored outside RUN.
- Latency: start sampled at edge N gives CONFIG outputs after N, CLEAR after N+1, and RUN (cpu_rst = 0) after N+2.
- The done-event compare snoops the CPU bus combinationally and is registered into the state; nothing is written to memory from it.
- Reset mid-CONFIG or mid-CLEAR: the partial write is abandoned and the next start rewrites both words.

Test Plan:
1. rst for 2 cycles → cpu_rst = 1, mem_sel = 1, every other output 0, state IDLE; start while rst = 1 → ignored.
2. start with filter_sel = 2 → next cycle mem_we = 1, mem_addr = 18'h3FFF0, mem_wdata = 8'h02. Following cycle mem_addr = 18'h3FFF1, mem_wdata = 0. Then cpu_rst = 0, mem_sel = 0, busy = 1.
3. In RUN, after 100 cycles drive cpu_mem_we = 1, addr = 18'h3FFF1, wdata = 8'h01 → done = 1, display_en = 1, cpu_rst = 1, cycles = 101 and stays frozen. A write of 8'h00 to DONE_ADDR instead → stays in RUN.
4. TIMEOUT_CYCLES = 50, no done write → error = 1 after exactly 50 RUN cycles, cpu_rst = 1. Same setup with the done write on cycle 50 → done = 1, error = 0.
5. abort on RUN cycle 10 → IDLE next cycle, cpu_rst = 1, busy = 0, done = 0. A simultaneous done write → still IDLE.
6. From DONE, start with filter_sel = 3 → display_en drops, CONFIG writes 8'h03, cycles reset to 0. start pulses during RUN → no effect.

Source files
------------

// File: rtl/filter_sequencer.sv
// filter_sequencer
// Run controller for the filter processor and its dual-port frame memory.
// While idle it holds the CPU in reset and owns memory port A. On start it
// writes the selected filter code to the config word, clears the completion
// flag word, then releases the CPU. It watches the CPU bus for the
// completion write, hands the frame to the display path, and flags runs that
// exceed the cycle budget. Port B (display read side) is not touched here.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   start           single-cycle run request (ignored while busy)
//   abort           cancels a run in progress (only honoured in RUN)
//   filter_sel      filter code, captured on start
//   cpu_mem_*       snooped CPU data-memory write bus
//   cpu_rst         CPU reset, 1 = held in reset
//   mem_sel         port A mux select, 1 = sequencer owns port A
//   mem_we/addr/wdata  sequencer side of port A
//   busy            high in CONFIG, CLEAR and RUN
//   done/display_en run completed, frame ready for display
//   error           run timed out
//   cycles          RUN cycles in the last or current run (saturating)
module filter_sequencer #(
  parameter int                ADDR_W         = 18,
  parameter int                DATA_W         = 8,
  parameter logic [ADDR_W-1:0] CFG_ADDR       = 18'h3FFF0,
  parameter logic [ADDR_W-1:0] DONE_ADDR      = 18'h3FFF1,
  parameter int                TIMEOUT_CYCLES = 10_000_000,
  parameter int                CNT_W          = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        filter_sel,
  input  logic              cpu_mem_we,
  input  logic [ADDR_W-1:0] cpu_mem_addr,
  input  logic [DATA_W-1:0] cpu_mem_wdata,
  output logic              cpu_rst,
  output logic              mem_sel,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              display_en,
  output logic [CNT_W-1:0]  cycles
);

  typedef enum logic [2:0] {
    S_IDLE, S_CONFIG, S_CLEAR, S_RUN, S_DONE, S_FAULT
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state, state_nxt;

  logic              done_evt;
  logic              timeout_hit;

  logic              cpu_rst_nxt, mem_sel_nxt, mem_we_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [DATA_W-1:0] mem_wdata_nxt;
  logic              busy_nxt, done_nxt, error_nxt, display_en_nxt;
  logic [CNT_W-1:0]  cycles_nxt;

  // Completion is a non-zero write to the flag word; a zero write is the
  // program clearing its own flag and must not end the run.
  assign done_evt    = cpu_mem_we && (cpu_mem_addr == DONE_ADDR) && (cpu_mem_wdata != '0);
  assign timeout_hit = (cycles == CNT_LAST);

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cpu_rst    <= 1'b1;
      mem_sel    <= 1'b1;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      display_en <= 1'b0;
      cycles     <= '0;
    end else begin
      state      <= state_nxt;
      cpu_rst    <= cpu_rst_nxt;
      mem_sel    <= mem_sel_nxt;
      mem_we     <= mem_we_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wdata  <= mem_wdata_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      error      <= error_nxt;
      display_en <= display_en_nxt;
      cycles     <= cycles_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_CONFIG;
      S_CONFIG: state_nxt = S_CLEAR;
      S_CLEAR:  state_nxt = S_RUN;
      S_RUN: begin
        // abort beats completion, completion beats timeout
        if (abort)            state_nxt = S_IDLE;
        else if (done_evt)    state_nxt = S_DONE;
        else if (timeout_hit) state_nxt = S_FAULT;
      end
      S_DONE:   if (start) state_nxt = S_CONFIG;
      S_FAULT:  if (start) state_nxt = S_CONFIG;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Output logic: values for the state being entered, so every output is
  // registered and lines up with the state it describes.
  always_comb begin
    cpu_rst_nxt    = 1'b1;
    mem_sel_nxt    = 1'b1;
    mem_we_nxt     = 1'b0;
    mem_addr_nxt   = '0;
    mem_wdata_nxt  = '0;
    busy_nxt       = 1'b0;
    done_nxt       = 1'b0;
    error_nxt      = 1'b0;
    display_en_nxt = 1'b0;
    case (state_nxt)
      S_CONFIG: begin
        // CONFIG is only entered on the start edge, so filter_sel is the
        // sampled code; the mem_wdata register holds it for the write.
        mem_we_nxt    = 1'b1;
        mem_addr_nxt  = CFG_ADDR;
        mem_wdata_nxt = {{(DATA_W-2){1'b0}}, filter_sel};
        busy_nxt      = 1'b1;
      end
      S_CLEAR: begin
        mem_we_nxt   = 1'b1;
        mem_addr_nxt = DONE_ADDR;
        busy_nxt     = 1'b1;
      end
      S_RUN: begin
        cpu_rst_nxt = 1'b0;
        mem_sel_nxt = 1'b0;
        busy_nxt    = 1'b1;
      end
      S_DONE: begin
        done_nxt       = 1'b1;
        display_en_nxt = 1'b1;
      end
      S_FAULT: error_nxt = 1'b1;
      default: ;
    endcase

    // Counts every RUN cycle, including the one in which the run ends.
    cycles_nxt = cycles;
    if (state_nxt == S_CONFIG)
      cycles_nxt = '0;
    else if (state == S_RUN && cycles != CNT_MAX)
      cycles_nxt = cycles + CNT_ONE;
  end

endmodule
